// File: rtl/ctrl_preempcao_if.sv
// Handshake bundle between the OS/pipeline side and the preemption controller.
interface ctrl_preempcao_if #(
  parameter int unsigned LARG_Q = 16
);
  logic              quantum_wr;
  logic [LARG_Q-1:0] quantum_in;
  logic              inicia_proc;
  logic              instr_valid;
  logic [31:0]       prox_pc;
  logic              halt_proc;
  logic              swap_SO;
  logic [31:0]       endRetRS;
  logic              em_usuario;
  logic [1:0]        motivo;
  logic [LARG_Q-1:0] restante;

  // OS/pipeline side: drives requests, observes controller status.
  modport master (
    output quantum_wr, quantum_in, inicia_proc, instr_valid, prox_pc, halt_proc,
    input  swap_SO, endRetRS, em_usuario, motivo, restante
  );

  // Controller side.
  modport slave (
    input  quantum_wr, quantum_in, inicia_proc, instr_valid, prox_pc, halt_proc,
    output swap_SO, endRetRS, em_usuario, motivo, restante
  );
endinterface

// File: rtl/ctrl_preempcao.sv
// Preemption controller: counts retired user instructions against a quantum and
// requests an OS swap on expiry or on a halt/syscall, capturing the return PC.
module ctrl_preempcao #(
  parameter int unsigned LARG_Q         = 16,
  parameter int unsigned QUANTUM_PADRAO = 100
) (
  input logic               clk,
  input logic               rst,
  ctrl_preempcao_if.slave   bus
);

  typedef enum logic [1:0] {StOcioso, StUsuario, StTroca} estado_e;

  localparam logic [1:0] MotivoNenhum  = 2'd0;
  localparam logic [1:0] MotivoQuantum = 2'd1;
  localparam logic [1:0] MotivoHalt    = 2'd2;

  estado_e           estado_q;
  logic [LARG_Q-1:0] quantum_q;
  logic [LARG_Q-1:0] restante_q;
  logic [31:0]       end_ret_q;
  logic [1:0]        motivo_q;

  logic quantum_ativo;
  logic restante_zero;
  logic ultimo;

  assign quantum_ativo = (quantum_q != '0);
  assign restante_zero = (restante_q == '0);
  assign ultimo        = (restante_q == LARG_Q'(1));

  // State machine and all controller registers; quantum writes are honoured in every state.
  always_ff @(posedge clk) begin
    if (rst) begin
      estado_q   <= StOcioso;
      quantum_q  <= LARG_Q'(QUANTUM_PADRAO);
      restante_q <= '0;
      end_ret_q  <= '0;
      motivo_q   <= MotivoNenhum;
    end else begin
      if (bus.quantum_wr) begin
        quantum_q <= bus.quantum_in;
      end
      unique case (estado_q)
        StOcioso: begin
          if (bus.inicia_proc) begin
            estado_q   <= StUsuario;
            restante_q <= quantum_q;
            motivo_q   <= MotivoNenhum;
          end
        end
        StUsuario: begin
          if (bus.instr_valid) begin
            // The halting instruction still retires, so it consumes quantum too;
            // the guard on zero keeps restante from wrapping.
            if (quantum_ativo && !restante_zero) begin
              restante_q <= restante_q - LARG_Q'(1);
            end
            if (bus.halt_proc) begin
              estado_q  <= StTroca;
              end_ret_q <= bus.prox_pc;
              motivo_q  <= MotivoHalt;
            end else if (quantum_ativo && ultimo) begin
              estado_q  <= StTroca;
              end_ret_q <= bus.prox_pc;
              motivo_q  <= MotivoQuantum;
            end
          end
        end
        StTroca: begin
          estado_q <= StOcioso;
        end
        default: begin
          estado_q <= StOcioso;
        end
      endcase
    end
  end

  // Outputs decoded from registered state only.
  always_comb begin
    bus.swap_SO    = (estado_q == StTroca);
    bus.em_usuario = (estado_q == StUsuario);
    bus.endRetRS   = end_ret_q;
    bus.motivo     = motivo_q;
    bus.restante   = restante_q;
  end

endmodule

// File: tb/tb_ctrl_preempcao.sv
// Directed self-checking bench for ctrl_preempcao.
module tb_ctrl_preempcao;

  logic clk;
  logic rst;

  int n_cmp;
  int n_err;

  ctrl_preempcao_if #(.LARG_Q(16)) bus ();

  ctrl_preempcao #(
    .LARG_Q         (16),
    .QUANTUM_PADRAO (100)
  ) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  // Advance one clock; outputs are then sampled 1 ns after the edge.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic wr_quantum(input logic [15:0] v);
    bus.quantum_wr = 1'b1;
    bus.quantum_in = v;
    tick();
    bus.quantum_wr = 1'b0;
  endtask

  task automatic launch();
    bus.inicia_proc = 1'b1;
    tick();
    bus.inicia_proc = 1'b0;
  endtask

  task automatic instr(input logic [31:0] pc, input logic halt);
    bus.instr_valid = 1'b1;
    bus.prox_pc     = pc;
    bus.halt_proc   = halt;
    tick();
    bus.instr_valid = 1'b0;
    bus.halt_proc   = 1'b0;
  endtask

  initial begin
    int swaps;
    n_cmp = 0;
    n_err = 0;
    rst             = 1'b1;
    bus.quantum_wr  = 1'b0;
    bus.quantum_in  = '0;
    bus.inicia_proc = 1'b0;
    bus.instr_valid = 1'b0;
    bus.prox_pc     = '0;
    bus.halt_proc   = 1'b0;

    // Reset
    tick();
    tick();
    rst = 1'b0;
    check("rst_swap", 32'(bus.swap_SO), 0);
    check("rst_em", 32'(bus.em_usuario), 0);
    check("rst_endret", bus.endRetRS, 0);
    check("rst_motivo", 32'(bus.motivo), 0);
    check("rst_restante", 32'(bus.restante), 0);
    launch();
    check("dflt_em", 32'(bus.em_usuario), 1);
    check("dflt_restante", 32'(bus.restante), 100);
    instr(32'd7, 1'b1);
    tick();

    // Quantum expiry after 3 instructions
    wr_quantum(16'd3);
    launch();
    instr(32'd40, 1'b0);
    check("q3_swap_early", 32'(bus.swap_SO), 0);
    check("q3_restante1", 32'(bus.restante), 2);
    instr(32'd41, 1'b0);
    instr(32'd42, 1'b0);
    check("q3_swap", 32'(bus.swap_SO), 1);
    check("q3_endret", bus.endRetRS, 42);
    check("q3_motivo", 32'(bus.motivo), 1);
    check("q3_em", 32'(bus.em_usuario), 0);
    check("q3_restante", 32'(bus.restante), 0);
    tick();
    check("q3_swap_end", 32'(bus.swap_SO), 0);
    check("q3_motivo_hold", 32'(bus.motivo), 1);

    // Syscall on the 4th instruction of a 10-quantum
    wr_quantum(16'd10);
    launch();
    check("sys_motivo_clr", 32'(bus.motivo), 0);
    instr(32'd50, 1'b0);
    instr(32'd51, 1'b0);
    instr(32'd52, 1'b0);
    instr(32'd57, 1'b1);
    check("sys_swap", 32'(bus.swap_SO), 1);
    check("sys_endret", bus.endRetRS, 57);
    check("sys_motivo", 32'(bus.motivo), 2);
    check("sys_restante", 32'(bus.restante), 6);
    tick();

    // Halt and expiry on the same instruction: halt wins
    wr_quantum(16'd2);
    launch();
    instr(32'd60, 1'b0);
    check("both_restante1", 32'(bus.restante), 1);
    instr(32'd61, 1'b1);
    check("both_swap", 32'(bus.swap_SO), 1);
    check("both_motivo", 32'(bus.motivo), 2);
    check("both_endret", bus.endRetRS, 61);
    tick();
    check("both_single_pulse", 32'(bus.swap_SO), 0);

    // Minimum quantum: expires on the first instruction
    wr_quantum(16'd1);
    launch();
    instr(32'd5, 1'b0);
    check("q1_swap", 32'(bus.swap_SO), 1);
    check("q1_motivo", 32'(bus.motivo), 1);
    tick();

    // Disabled quantum
    wr_quantum(16'd0);
    launch();
    swaps = 0;
    for (int i = 0; i < 500; i++) begin
      instr(32'(1000 + i), 1'b0);
      if (bus.swap_SO) swaps++;
    end
    check("dis_swaps", 32'(swaps), 0);
    check("dis_restante", 32'(bus.restante), 0);
    check("dis_em", 32'(bus.em_usuario), 1);
    instr(32'd99, 1'b1);
    check("dis_halt_swap", 32'(bus.swap_SO), 1);
    check("dis_halt_motivo", 32'(bus.motivo), 2);
    check("dis_halt_endret", bus.endRetRS, 99);
    tick();

    // Quantum write during a run does not disturb the running count
    wr_quantum(16'd8);
    launch();
    check("wr_restante0", 32'(bus.restante), 8);
    wr_quantum(16'd5);
    check("wr_restante_keep", 32'(bus.restante), 8);
    for (int i = 0; i < 7; i++) instr(32'(200 + i), 1'b0);
    check("wr_swap_early", 32'(bus.swap_SO), 0);
    check("wr_restante7", 32'(bus.restante), 1);
    instr(32'd207, 1'b0);
    check("wr_swap", 32'(bus.swap_SO), 1);
    check("wr_motivo", 32'(bus.motivo), 1);
    tick();
    launch();
    check("wr_next_restante", 32'(bus.restante), 5);

    // Reset during the swap cycle cancels the pulse
    for (int i = 0; i < 4; i++) instr(32'(300 + i), 1'b0);
    instr(32'd77, 1'b0);
    check("rt_swap", 32'(bus.swap_SO), 1);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    check("rt_swap_cancel", 32'(bus.swap_SO), 0);
    check("rt_em", 32'(bus.em_usuario), 0);
    check("rt_motivo", 32'(bus.motivo), 0);
    check("rt_endret", bus.endRetRS, 0);
    check("rt_restante", 32'(bus.restante), 0);
    launch();
    check("rt_quantum_dflt", 32'(bus.restante), 100);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/ctrl_preempcao.md
# ctrl_preempcao

Preemption controller for the user-process/OS time-sharing scheme. Counts instructions retired by the running user process against a programmable quantum. Ends the process on quantum expiry or on a voluntary halt/syscall by capturing the return address and pulsing the OS-swap request. Sits directly upstream of the next-instruction multiplexer: drives its `swap_SO` and `endRetRS` inputs and consumes its next-PC output.

## Interface
- `LARG_Q`, 16: width of the quantum register and counter.
- `QUANTUM_PADRAO`, 100: quantum value loaded at reset.
- `clk`  in  1  system clock; all state changes on the rising edge.
- `rst`  in  1  synchronous, active-high reset.
- `quantum_wr`  in  1  OS writes a new quantum value.
- `quantum_in`  in  LARG_Q  new quantum value; 0 disables preemption.
- `inicia_proc`  in  1  OS launches the user process (jump to process executed this cycle).
- `instr_valid`  in  1  one instruction retired this cycle.
- `prox_pc`  in  32  next-PC value produced by the next-instruction mux this cycle.
- `halt_proc`  in  1  retiring instruction is a halt/syscall; qualified by `instr_valid`.
- `swap_SO`  out  1  one-cycle OS-resume request to the next-instruction mux.
- `endRetRS`  out  32  saved process return address.
- `em_usuario`  out  1  high while state is USUARIO.
- `motivo`  out  2  last swap cause: 0 none, 1 quantum expired, 2 halt/syscall.
- `restante`  out  LARG_Q  instructions left in the current quantum.

## Operation
- Registers: `quantum_reg`, `restante`, `endRetRS`, `motivo`, and a 2-bit state.
- States:
  - OCIOSO: OS running.
  - USUARIO: process running.
  - TROCA: swap pulse.
- OCIOSO:
  - `inicia_proc` → USUARIO.
  - On the same edge, `restante <= quantum_reg` and `motivo <= 0`.
  - `instr_valid` and `halt_proc` are ignored.
- USUARIO, with `instr_valid=1` and `halt_proc=1`:
  - → TROCA.
  - `endRetRS <= prox_pc`, `motivo <= 2`.
  - This case has priority over quantum expiry on the same edge.
- USUARIO, with `instr_valid=1`, `halt_proc=0`, `quantum_reg != 0` and `restante == 1`:
  - → TROCA.
  - `endRetRS <= prox_pc`, `motivo <= 1`, `restante <= 0`.
- USUARIO, any other `instr_valid=1` case with `quantum_reg != 0`: `restante <= restante - 1`.
- `quantum_reg == 0` in USUARIO: no decrement and no quantum expiry; only halt/syscall ends the process.
- TROCA:
  - `swap_SO = 1` for exactly this cycle.
  - → OCIOSO unconditionally.
  - All inputs except `quantum_wr` are ignored.
- `quantum_wr` in any state:
  - `quantum_reg <= quantum_in`.
  - Does not alter a running `restante`; takes effect at the next `inicia_proc`.
- `inicia_proc` in USUARIO or TROCA: ignored.
- `restante` never wraps below 0. Arithmetic is unsigned, LARG_Q bits.
- `endRetRS` holds its value until the next capture. `motivo` holds until the next `inicia_proc`.

## Timing
- Outputs after `rst`:
  - state = OCIOSO
  - `swap_SO=0`, `em_usuario=0`
  - `endRetRS=0`, `motivo=0`, `restante=0`
  - `quantum_reg=QUANTUM_PADRAO`
- All outputs are registered or decoded from registered state only; none is combinational from inputs.
- Latency: terminating instruction retires in cycle N (captured at the end of N) → `swap_SO=1` in cycle N+1 → mux forces the OS entry address in N+1 → PC loads it at the end of N+1.
- `em_usuario` rises the cycle after `inicia_proc` and falls on entry to TROCA.
- `rst` mid-USUARIO or mid-TROCA:
  - Returns to OCIOSO with reset values on the next edge.
  - A pending `swap_SO` pulse is cancelled.
- Minimum process length is 1 instruction (quantum 1): expiry on the first `instr_valid`.

## Test plan
- Reset: assert `rst` 2 cycles → all outputs 0, `restante=0`; then launch without `quantum_wr` → `restante=100`.
- Quantum expiry: `quantum_in=3`, launch, 3× `instr_valid` with `prox_pc`=40, 41, 42 → `swap_SO` high exactly one cycle after the 3rd, `endRetRS=42`, `motivo=1`, `em_usuario=0`.
- Syscall: quantum 10, 4 instructions, `halt_proc` on the 4th with `prox_pc=57` → `swap_SO` pulse, `endRetRS=57`, `motivo=2`, `restante=6`.
- Simultaneous halt and expiry: quantum 2, `halt_proc` on the 2nd instruction → `motivo=2`, single `swap_SO` pulse.
- Disabled quantum: `quantum_in=0`, 500 instructions → no `swap_SO`, `restante=0`. Then `halt_proc` → swap with `motivo=2`.
- Reset mid-run and write during run:
  - `quantum_wr=5` while in USUARIO with `restante=8` → current run expires after 8 instructions; the next run starts with 5.
  - `rst` in the TROCA cycle → `swap_SO` low next cycle, state OCIOSO.
